// File: rtl/hash_pipe_pkg.sv
// Shared types for the hash pipeline scheduler: op encoding, tag record, write-op helper.
package hash_pipe_pkg;

  // Wide enough for any practical requester count; the top truncates to ID_WIDTH.
  localparam int TAG_ID_W = 8;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2
  } op_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    op_t                 op;
  } tag_t;

  // Insert and delete modify the table; everything else (including the reserved code) reads it.
  function automatic logic is_write(op_t op);
    return (op == OP_INSERT) || (op == OP_DELETE);
  endfunction

endpackage

// File: rtl/hash_pipe_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible index at or after the pointer, with wrap-around.
// The pointer moves to one past the winner only when the advance strobe accepts the grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               any_grant_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Search upward from the pointer and precompute the pointer value following the winner.
  always_comb begin
    int idx;
    grant_o     = '0;
    any_grant_o = 1'b0;
    ptr_d       = ptr_q;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_grant_o && eligible_i[idx]) begin
        grant_o[idx] = 1'b1;
        any_grant_o  = 1'b1;
        ptr_d        = (idx == NUM_REQ - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Pointer register: holds unless a grant is actually consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance_i && any_grant_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hash_pipe_scheduler.sv
// Shares one fixed-latency hash pipeline between NUM_REQ requesters.
// A tag delay line mirrors the external pipeline so each result is routed back to its issuer;
// a stalled response port freezes the whole pipeline through pipe_en.
// Optional macro HASH_PIPE_HAZARD_CHECK_EN adds a key delay line and holds off any requester
// whose key matches an in-flight insert/delete (read-after-write ordering per key).
//
// Handshake: a request transfers in a cycle where req_valid[i] && req_ready[i]; requesters keep
// valid/op/key stable until then. A response transfers when rsp_valid && rsp_ready; until then
// rsp_id/rsp_data hold because the pipeline does not advance.
module hash_pipe_scheduler
  import hash_pipe_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int KEY_WIDTH    = 32,
  parameter int RESULT_WIDTH = 33,
  parameter int PIPE_DELAY   = 3,
  parameter int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*2-1:0]          req_op,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]  req_key,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          pipe_en,
  output logic                          pipe_valid_o,
  output logic [1:0]                    pipe_op_o,
  output logic [KEY_WIDTH-1:0]          pipe_key_o,
  input  logic [RESULT_WIDTH-1:0]       pipe_result_i,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [RESULT_WIDTH-1:0]       rsp_data,
  input  logic                          rsp_ready,
  output logic [$clog2(PIPE_DELAY+1)-1:0] in_flight
);

  localparam int IF_W = $clog2(PIPE_DELAY + 1);

  tag_t               tag_q [PIPE_DELAY];
  tag_t               tail;
  tag_t               issue_tag;
  logic [NUM_REQ-1:0] blocked;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic [ID_WIDTH-1:0] gid;
  logic [IF_W-1:0]    in_flight_q;
  logic               rsp_fire;

  assign tail     = tag_q[PIPE_DELAY-1];
  assign pipe_en  = !tail.valid || rsp_ready;
  assign rsp_valid = tail.valid && !reset;
  assign rsp_id   = tail.id[ID_WIDTH-1:0];
  assign rsp_data = pipe_result_i;
  assign rsp_fire = rsp_valid && rsp_ready;

`ifdef HASH_PIPE_HAZARD_CHECK_EN
  logic [KEY_WIDTH-1:0] key_q [PIPE_DELAY];

  // Key delay line, shifting in lockstep with the tags; only meaningful where the tag is valid.
  always_ff @(posedge clk) begin
    if (pipe_en) begin
      key_q[0] <= pipe_key_o;
      for (int k = 1; k < PIPE_DELAY; k++) key_q[k] <= key_q[k-1];
    end
  end

  // A requester whose key hits any in-flight write must wait until that write has drained.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < PIPE_DELAY; k++) begin
        if (tag_q[k].valid && is_write(tag_q[k].op) &&
            key_q[k] == req_key[i*KEY_WIDTH +: KEY_WIDTH]) begin
          blocked[i] = 1'b1;
        end
      end
    end
  end
`else
  assign blocked = '0;
`endif

  // Nothing can issue while frozen or in reset.
  assign eligible  = req_valid & ~blocked & {NUM_REQ{pipe_en && !reset}};
  assign req_ready = grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .eligible_i (eligible),
    .advance_i  (pipe_en),
    .grant_o    (grant),
    .any_grant_o(any_grant)
  );

  // Select the winner's op/key onto the issue port; zero when idle.
  always_comb begin
    gid          = '0;
    pipe_valid_o = any_grant;
    pipe_op_o    = '0;
    pipe_key_o   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gid        = ID_WIDTH'(i);
        pipe_op_o  = req_op[i*2 +: 2];
        pipe_key_o = req_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
    issue_tag.valid = any_grant;
    issue_tag.id    = TAG_ID_W'(gid);
    issue_tag.op    = op_t'(pipe_op_o);
  end

  // Tag delay line: shifts with the pipeline, reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < PIPE_DELAY; k++) tag_q[k] <= '0;
    end else if (pipe_en) begin
      tag_q[0] <= issue_tag;
      for (int k = 1; k < PIPE_DELAY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // Occupancy counter: up on issue, down on delivered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight_q <= '0;
    end else if (any_grant && !rsp_fire) begin
      in_flight_q <= in_flight_q + IF_W'(1);
    end else if (!any_grant && rsp_fire) begin
      in_flight_q <= in_flight_q - IF_W'(1);
    end
  end

  assign in_flight = in_flight_q;

endmodule

// File: tb/tb_hash_pipe_scheduler.sv
// Testbench for hash_pipe_scheduler. Reference model: list of in-flight ops with ages counted in
// enabled cycles, plus an issue-order queue of requester ids.
module tb_hash_pipe_scheduler;

  localparam int NUM_REQ = 4;
  localparam int KW      = 32;
  localparam int RW      = 33;
  localparam int PD      = 3;
  localparam int ID_W    = 2;

  logic                    clk;
  logic                    reset;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*2-1:0]    req_op;
  logic [NUM_REQ*KW-1:0]   req_key;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    pipe_en;
  logic                    pipe_valid_o;
  logic [1:0]              pipe_op_o;
  logic [KW-1:0]           pipe_key_o;
  logic [RW-1:0]           pipe_result_i;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [RW-1:0]           rsp_data;
  logic                    rsp_ready;
  logic [1:0]              in_flight;

  hash_pipe_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_key(req_key),
    .req_ready(req_ready), .pipe_en(pipe_en), .pipe_valid_o(pipe_valid_o),
    .pipe_op_o(pipe_op_o), .pipe_key_o(pipe_key_o), .pipe_result_i(pipe_result_i),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .in_flight(in_flight)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] key;
    int          age;
  } item_t;

  item_t           mq[$];
  logic [ID_W-1:0] exp_q[$];
  int              m_ptr;
  int              m_grant;
  int              n_checks;
  int              n_fail;

  // Observations from the most recent tick
  int              dut_gidx;
  logic            dut_rsp_seen;
  logic [ID_W-1:0] dut_rsp_id;
  logic [RW-1:0]   dut_rsp_data;
  logic [1:0]      dut_in_flight;
  logic            dut_pipe_en;

  function automatic logic [RW-1:0] mk_res(logic [31:0] key, logic [1:0] op);
    return {op == 2'd1, key ^ 32'h5A5A_5A5A};
  endfunction

`ifdef HASH_PIPE_HAZARD_CHECK_EN
  function automatic bit blocked(int i);
    for (int j = 0; j < mq.size(); j++)
      if ((mq[j].op == 2'd1 || mq[j].op == 2'd2) && mq[j].key == req_key[i*KW +: KW]) return 1'b1;
    return 1'b0;
  endfunction
`else
  function automatic bit blocked(int i);
    return (i < 0);
  endfunction
`endif

  // One clock cycle: entered just after a negedge with inputs already driven.
  task automatic tick();
    bit tail;
    int g;
    logic [NUM_REQ-1:0] exp_ready;
    logic [RW-1:0] exp_res;
    logic exp_en;
    logic exp_rv;
    tail    = (mq.size() > 0) && (mq[0].age == PD - 1);
    exp_en  = !tail || rsp_ready;
    exp_rv  = tail && !reset;
    exp_res = '0;
    if (tail) begin
      exp_res       = mk_res(mq[0].key, mq[0].op);
      pipe_result_i = exp_res;
    end else begin
      pipe_result_i = {1'b0, 32'($urandom())};
    end
    g = -1;
    if (!reset && exp_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (m_ptr + k) % NUM_REQ;
        if (g < 0 && req_valid[i] && !blocked(i)) g = i;
      end
    end
    exp_ready = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
    #1;
    dut_gidx = -1;
    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) dut_gidx = i;
    dut_rsp_seen  = rsp_valid;
    dut_rsp_id    = rsp_id;
    dut_rsp_data  = rsp_data;
    dut_in_flight = in_flight;
    dut_pipe_en   = pipe_en;

    n_checks++;
    if (req_ready !== exp_ready) begin
      n_fail++; $display("FAIL req_ready: got %b expected %b at %0t", req_ready, exp_ready, $time);
    end
    n_checks++;
    if (pipe_en !== exp_en) begin
      n_fail++; $display("FAIL pipe_en: got %b expected %b at %0t", pipe_en, exp_en, $time);
    end
    n_checks++;
    if (pipe_valid_o !== (g >= 0)) begin
      n_fail++; $display("FAIL pipe_valid_o: got %b expected %b at %0t", pipe_valid_o, (g >= 0), $time);
    end
    if (g >= 0) begin
      n_checks++;
      if (pipe_op_o !== req_op[g*2 +: 2] || pipe_key_o !== req_key[g*KW +: KW]) begin
        n_fail++; $display("FAIL issue_payload: got %0h/%0h expected %0h/%0h", pipe_op_o, pipe_key_o, req_op[g*2 +: 2], req_key[g*KW +: KW]);
      end
    end else begin
      n_checks++;
      if (pipe_op_o !== 2'd0 || pipe_key_o !== '0) begin
        n_fail++; $display("FAIL idle_payload: got %0h/%0h expected 0/0", pipe_op_o, pipe_key_o);
      end
    end
    n_checks++;
    if (rsp_valid !== exp_rv) begin
      n_fail++; $display("FAIL rsp_valid: got %b expected %b at %0t", rsp_valid, exp_rv, $time);
    end
    if (exp_rv) begin
      n_checks++;
      if (rsp_id !== ID_W'(mq[0].id) || rsp_data !== exp_res) begin
        n_fail++; $display("FAIL rsp_payload: got %0d/%0h expected %0d/%0h", rsp_id, rsp_data, mq[0].id, exp_res);
      end
    end
    n_checks++;
    if (int'(in_flight) != mq.size()) begin
      n_fail++; $display("FAIL in_flight: got %0d expected %0d at %0t", in_flight, mq.size(), $time);
    end
    if (rsp_valid === 1'b1 && rsp_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL rsp_order: got id %0d expected no response", rsp_id);
      end else begin
        logic [ID_W-1:0] e;
        e = exp_q.pop_front();
        if (rsp_id !== e) begin
          n_fail++; $display("FAIL rsp_order: got id %0d expected %0d", rsp_id, e);
        end
      end
    end

    @(posedge clk);
    m_grant = g;
    if (reset) begin
      mq.delete();
      exp_q.delete();
      m_ptr = 0;
    end else if (exp_en) begin
      if (tail) void'(mq.pop_front());
      for (int j = 0; j < mq.size(); j++) mq[j].age++;
      if (g >= 0) begin
        item_t it;
        it.id  = g;
        it.op  = req_op[g*2 +: 2];
        it.key = req_key[g*KW +: KW];
        it.age = 0;
        mq.push_back(it);
        exp_q.push_back(ID_W'(g));
        m_ptr = (g + 1) % NUM_REQ;
      end
    end
    @(negedge clk);
  endtask

  // Driver tasks
  task automatic set_req(int i, logic v, logic [1:0] op, logic [31:0] key);
    req_valid[i]        = v;
    req_op[i*2 +: 2]    = op;
    req_key[i*KW +: KW] = key;
  endtask

  task automatic drain(int n);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '1;
    repeat (2) begin
      tick();
      n_checks++;
      if (dut_gidx != -1 || dut_rsp_seen !== 1'b0 || dut_in_flight !== 2'd0) begin
        n_fail++; $display("FAIL reset_hold: got grant %0d rsp %b inflight %0d expected -1/0/0", dut_gidx, dut_rsp_seen, dut_in_flight);
      end
    end
    reset     = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 2'd0, 32'h100 + i);
    rsp_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (t < 5) begin
        n_checks++;
        if (dut_gidx != t % NUM_REQ) begin
          n_fail++; $display("FAIL rr_grant: got %0d expected %0d", dut_gidx, t % NUM_REQ);
        end
      end
      if (t == 4) begin
        n_checks++;
        if (dut_in_flight !== 2'd3) begin
          n_fail++; $display("FAIL rr_saturate: got %0d expected 3", dut_in_flight);
        end
      end
      if (m_grant >= 0) set_req(m_grant, 1'b1, 2'd0, 32'h200 + t);
    end
    drain(4);
  endtask

  task automatic test_single();
    int lat;
    set_req(2, 1'b1, 2'd0, 32'hAB);
    tick();
    req_valid = '0;
    n_checks++;
    if (dut_gidx != 2) begin
      n_fail++; $display("FAIL single_grant: got %0d expected 2", dut_gidx);
    end
    lat = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      lat++;
      if (dut_rsp_seen === 1'b1) break;
    end
    n_checks++;
    if (lat != PD || dut_rsp_id !== 2'd2 || dut_rsp_data !== mk_res(32'hAB, 2'd0)) begin
      n_fail++; $display("FAIL single_latency: got %0d cycles id %0d expected %0d cycles id 2", lat, dut_rsp_id, PD);
    end
    tick();
    n_checks++;
    if (dut_in_flight !== 2'd0) begin
      n_fail++; $display("FAIL single_drain: got %0d expected 0", dut_in_flight);
    end
  endtask

  task automatic test_stall();
    logic [ID_W-1:0] hold_id;
    logic [RW-1:0]   hold_data;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 2'd0, 32'h300 + i);
    rsp_ready = 1'b1;
    repeat (3) begin
      tick();
      if (m_grant >= 0) set_req(m_grant, 1'b1, 2'd0, 32'h380 + m_grant);
    end
    rsp_ready = 1'b0;
    hold_id   = '0;
    hold_data = '0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (t == 0) begin
        hold_id   = dut_rsp_id;
        hold_data = dut_rsp_data;
      end
      n_checks++;
      if (dut_pipe_en !== 1'b0 || dut_gidx != -1 || dut_rsp_seen !== 1'b1 ||
          dut_rsp_id !== hold_id || dut_rsp_data !== hold_data) begin
        n_fail++; $display("FAIL stall_hold: got en %b grant %0d rsp %b id %0d expected 0/-1/1/%0d", dut_pipe_en, dut_gidx, dut_rsp_seen, dut_rsp_id, hold_id);
      end
    end
    drain(6);
    n_checks++;
    if (exp_q.size() != 0 || dut_in_flight !== 2'd0) begin
      n_fail++; $display("FAIL stall_complete: got %0d pending inflight %0d expected 0/0", exp_q.size(), dut_in_flight);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 2'd1, 32'h400 + i);
    rsp_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    req_valid = '0;
    tick();
    n_checks++;
    if (dut_in_flight !== 2'd0) begin
      n_fail++; $display("FAIL reset_mid_inflight: got %0d expected 0", dut_in_flight);
    end
    seen = (dut_rsp_seen === 1'b1) ? 1 : 0;
    repeat (4) begin
      tick();
      if (dut_rsp_seen === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_mid_discard: got %0d responses expected 0", seen);
    end
  endtask

  task automatic test_hazard();
    int cnt;
    int first;
    int exp_first;
    int exp_cnt;
`ifdef HASH_PIPE_HAZARD_CHECK_EN
    exp_first = 2;
    exp_cnt   = PD + 1;
`else
    exp_first = 1;
    exp_cnt   = 1;
`endif
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 2'd1, 32'h10);
    tick();
    req_valid = '0;
    set_req(1, 1'b1, 2'd0, 32'h10);
    set_req(2, 1'b1, 2'd0, 32'h20);
    cnt   = 0;
    first = -2;
    for (int t = 0; t < 10; t++) begin
      tick();
      cnt++;
      if (first == -2) first = dut_gidx;
      if (m_grant == 2) req_valid[2] = 1'b0;
      if (dut_gidx == 1) break;
    end
    req_valid = '0;
    n_checks++;
    if (first != exp_first) begin
      n_fail++; $display("FAIL hazard_first: got %0d expected %0d", first, exp_first);
    end
    n_checks++;
    if (cnt != exp_cnt) begin
      n_fail++; $display("FAIL hazard_wait: got %0d cycles expected %0d", cnt, exp_cnt);
    end
    drain(5);
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && $urandom_range(0, 2) != 0)
          set_req(i, 1'b1, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 7)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
      if (m_grant >= 0) req_valid[m_grant] = 1'b0;
    end
    reset = 1'b0;
    drain(8);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    m_ptr         = 0;
    m_grant       = -1;
    reset         = 1'b1;
    req_valid     = '0;
    req_op        = '0;
    req_key       = '0;
    rsp_ready     = 1'b1;
    pipe_result_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_single();
    test_stall();
    test_reset_mid();
    test_hazard();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hash_pipe_scheduler.md
Name: hash_pipe_scheduler

Overview:
- Shares one fixed-latency hash-table pipeline (PIPE_DELAY enabled stages, built from shift-register delay lines) between NUM_REQ requesters.
- Round-robin arbitrates requests and drives the common pipeline advance enable.
- Tracks in-flight operations with an internal tag delay line and routes each pipeline result back to the requester that issued it.
- Applies backpressure by freezing the whole pipeline when the response port stalls.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- KEY_WIDTH, 32, hash key width.
- RESULT_WIDTH, 33, pipeline result width (value plus hit flag).
- PIPE_DELAY, 3, pipeline latency in enabled cycles (>=1).
- ID_WIDTH, $clog2(NUM_REQ), requester id width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_op  in  NUM_REQ*2  per-requester op: 0 lookup, 1 insert, 2 delete, 3 reserved (treated as lookup)
- req_key  in  NUM_REQ*KEY_WIDTH  per-requester key
- req_ready  out  NUM_REQ  one-hot grant/accept
- pipe_en  out  1  advance enable for every pipeline stage
- pipe_valid_o  out  1  issue valid into pipeline stage 0
- pipe_op_o  out  2  issued op
- pipe_key_o  out  KEY_WIDTH  issued key
- pipe_result_i  in  RESULT_WIDTH  result from the last pipeline stage
- rsp_valid  out  1  response valid
- rsp_id  out  ID_WIDTH  target requester
- rsp_data  out  RESULT_WIDTH  response payload
- rsp_ready  in  1  response consumer accept
- in_flight  out  $clog2(PIPE_DELAY+1)  number of occupied tag stages

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values:
  - All tag-stage valid bits 0.
  - RR pointer 0.
  - in_flight 0.
  - rsp_valid, pipe_valid_o and req_ready are 0 while reset is high.
- Tag line: PIPE_DELAY stages of {valid, id, op}.
  - Stage 0 loads the issue tag; stage k loads stage k-1.
  - Shifts only when pipe_en=1. Holds all contents otherwise.
  - Tail = stage PIPE_DELAY-1.
- pipe_en = !tail.valid || rsp_ready (combinational).
- Response:
  - rsp_valid = tail.valid, rsp_id = tail.id, rsp_data = pipe_result_i (pass-through, no register).
  - Handshake completes on rsp_valid && rsp_ready.
  - While stalled, rsp_* hold stable because the pipeline is frozen.
- Arbitration:
  - Eligible = req_valid[i] (further gated under the optional feature).
  - Grant goes to the first eligible index at or after the pointer, searching upward with wrap-around.
  - Issue occurs when pipe_en=1 and any request is eligible. In that cycle req_ready[g]=1, pipe_valid_o=1, and pipe_op_o/pipe_key_o take requester g's values.
  - No issue occurs while pipe_en=0. All req_ready are 0.
  - After an issue, pointer = (g+1) mod NUM_REQ. With no issue, the pointer holds.
  - req_ready may depend combinationally on req_valid. Requesters must hold req_valid/op/key stable until accepted.
- Latency: a request accepted in cycle t produces rsp_valid in cycle t+PIPE_DELAY, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one issue per cycle when rsp_ready=1.
- in_flight:
  - +1 on issue, -1 on completed response, unchanged when both or neither occur.
  - Never exceeds PIPE_DELAY.
- pipe_op/pipe_key are don't-care when pipe_valid_o=0 and are driven 0.
- Reset mid-operation: all in-flight tags are discarded and no response is produced for them. The external pipeline shares the same reset.

Optional Feature:
- Macro HASH_PIPE_HAZARD_CHECK_EN.
- When defined:
  - A parallel key delay line (PIPE_DELAY x KEY_WIDTH, shifting with the tags) is kept.
  - A requester is ineligible if its key equals the key of any valid in-flight stage whose op is insert or delete.
  - The ineligible requester is skipped by the RR search and receives no ready.
  - This guarantees read-after-write ordering per key.
- When undefined: no key storage and no comparison. All valid requests are eligible.

Decomposition:
- Package hash_pipe_pkg holds:
  - op_t enum (OP_LOOKUP=0, OP_INSERT=1, OP_DELETE=2).
  - Tag struct {valid, id, op}.
  - Function is_write(op_t).
- One sub-module, rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: eligible vector, advance strobe.
  - Outputs: one-hot grant, any_grant.
  - Owns the pointer.

Test Plan (NUM_REQ=4, PIPE_DELAY=3 unless noted):
- Reset, then hold reset for 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, in_flight=0 throughout.
- All four requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles. rsp_id sequence 0,1,2,3 starts 3 cycles after the first grant. in_flight saturates at 3.
- Single request from requester 2, key 0xAB, op lookup, rsp_ready=1 -> rsp_valid exactly 3 cycles later with rsp_id=2. in_flight returns to 0.
- Fill the pipeline, then drop rsp_ready for 5 cycles -> pipe_en=0, req_ready=0 and rsp_* stable for 5 cycles. Order is preserved after release with no lost or duplicated response.
- Reset asserted while 3 ops are in flight -> next cycle in_flight=0. No rsp_valid for the discarded ops.
- With HASH_PIPE_HAZARD_CHECK_EN: requester 0 issues insert of key 0x10. Requester 1 lookup of 0x10 and requester 2 lookup of 0x20 are valid next -> requester 2 is granted, and requester 1 is granted only after the insert leaves the tail. Without the macro, requester 1 is granted immediately.
